digital_adc: RTL and testbench

- Digital back-end of a single-slope (ramp-compare) 8-bit ADC.
- On a `restart` request it resets the analog ramp, lets the ramp settle, then enables the ramp while counting clock cycles.
- It stops counting when the analog comparator trips and publishes the count as the conversion result.
- Sits between the analog ramp generator / comparator and the digital consumer of samples; nominal clock 1 MHz.

---
 rtl/digital_adc_pkg.sv | 24 ++
 rtl/digital_adc_sync_2ff.sv | 25 ++
 rtl/digital_adc.sv | 127 ++++++++++++
 tb/tb_digital_adc.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/digital_adc_pkg.sv
// Shared types and constants for the single-slope ADC back-end.
package digital_adc_pkg;

    // Conversion sequencer states
    typedef enum logic [1:0] {
        StIdle,
        StRampRst,
        StConvert,
        StDone
    } state_e;

    localparam int unsigned     CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;
    localparam int unsigned     SYNC_LAT = 2;

    // a - b, clamped at zero instead of wrapping
    function automatic logic [CNT_W-1:0] floor_sub(input logic [CNT_W-1:0] a,
                                                   input logic [CNT_W-1:0] b);
        logic [CNT_W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        return diff[CNT_W] ? '0 : diff[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/digital_adc_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Shift the input through two flops to resolve metastability
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/digital_adc.sv
// Digital back-end of a single-slope 8-bit ADC: sequences ramp reset/enable,
// counts clocks until the comparator trips and publishes the count.
module digital_adc
    import digital_adc_pkg::*;
#(
    parameter int unsigned ASYNC        = 1,
    parameter int unsigned RESET_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             comp_out,
    input  logic             restart,
    output logic             ramp_en,
    output logic             ramp_reset,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned      SetW       = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [SetW-1:0]  SettleLoad = SetW'(RESET_CYCLES - 1);
    // Cycles the synchronizer delays the trip; subtracted from the raw count
    localparam logic [CNT_W-1:0] LatV       = (ASYNC != 0) ? CNT_W'(SYNC_LAT) : '0;

    logic cs;

    if (ASYNC != 0) begin : g_sync
        sync_2ff u_sync (
            .clk  (clk),
            .rstn (rstn),
            .d    (comp_out),
            .q    (cs)
        );
    end else begin : g_direct
        assign cs = comp_out;
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SetW-1:0]  settle_q, settle_d;
    logic             ramp_en_q, ramp_en_d;
    logic             ramp_reset_q, ramp_reset_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next state plus the registered output values belonging to that state
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        settle_d     = settle_q;
        ramp_en_d    = ramp_en_q;
        ramp_reset_d = ramp_reset_q;
        busy_d       = busy_q;
        valid_d      = valid_q;
        count_d      = count_q;

        unique case (state_q)
            StIdle, StDone: begin
                // count is kept; only valid drops when a new conversion starts
                if (restart) begin
                    state_d      = StRampRst;
                    settle_d     = SettleLoad;
                    valid_d      = 1'b0;
                    busy_d       = 1'b1;
                    ramp_en_d    = 1'b0;
                    ramp_reset_d = 1'b1;
                end
            end
            StRampRst: begin
                if (settle_q == '0) begin
                    state_d      = StConvert;
                    cnt_d        = '0;
                    ramp_reset_d = 1'b0;
                    ramp_en_d    = 1'b1;
                end else begin
                    settle_d = settle_q - SetW'(1);
                end
            end
            StConvert: begin
                if (cs || (cnt_q == CNT_MAX)) begin
                    state_d      = StDone;
                    count_d      = cs ? floor_sub(cnt_q, LatV) : CNT_MAX;
                    valid_d      = 1'b1;
                    busy_d       = 1'b0;
                    ramp_en_d    = 1'b0;
                    ramp_reset_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            settle_q     <= '0;
            ramp_en_q    <= 1'b0;
            ramp_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            settle_q     <= settle_d;
            ramp_en_q    <= ramp_en_d;
            ramp_reset_q <= ramp_reset_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            count_q      <= count_d;
        end
    end

    assign ramp_en    = ramp_en_q;
    assign ramp_reset = ramp_reset_q;
    assign busy       = busy_q;
    assign valid      = valid_q;
    assign count      = count_q;

endmodule

// File: tb/tb_digital_adc.sv
// Bench for digital_adc: one instance with a direct comparator path and one
// with the synchronizer, both driven by the same stimulus.
module tb_digital_adc;
    import digital_adc_pkg::*;

    localparam int RC = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic       comp_out;
    logic       restart;

    logic       en0, rr0, bz0, vl0;
    logic [7:0] ct0;
    logic       en1, rr1, bz1, vl1;
    logic [7:0] ct1;

    int checks = 0;
    int errors = 0;
    int old0   = 0;
    int old1   = 0;

    typedef struct {
        string name;
        int    trip;   // first edge (relative to restart edge) where comp_out is 1
        int    rlen;   // number of edges restart is held high
        int    exp0;   // expected count, direct path
        int    exp1;   // expected count, synchronized path
    } vec_t;

    vec_t tbl[9];

    digital_adc #(.ASYNC(0), .RESET_CYCLES(RC)) dut0 (
        .clk        (clk),
        .rstn       (rstn),
        .comp_out   (comp_out),
        .restart    (restart),
        .ramp_en    (en0),
        .ramp_reset (rr0),
        .busy       (bz0),
        .valid      (vl0),
        .count      (ct0)
    );

    digital_adc #(.ASYNC(1), .RESET_CYCLES(RC)) dut1 (
        .clk        (clk),
        .rstn       (rstn),
        .comp_out   (comp_out),
        .restart    (restart),
        .ramp_en    (en1),
        .ramp_reset (rr1),
        .busy       (bz1),
        .valid      (vl1),
        .count      (ct1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_dut(input string tag, input logic en, input logic rr, input logic bz,
                           input logic vl, input logic [7:0] ct, input logic x_en,
                           input logic x_bz, input logic x_vl, input int x_ct);
        chk({tag, " ramp_en"}, 32'(en), 32'(x_en));
        chk({tag, " ramp_reset"}, 32'(rr), 32'(!x_en));
        chk({tag, " busy"}, 32'(bz), 32'(x_bz));
        chk({tag, " valid"}, 32'(vl), 32'(x_vl));
        chk({tag, " count"}, 32'(ct), 32'(x_ct));
    endtask

    // Index of the first CONVERT cycle whose sampled comparator reads 1, or -1.
    // CONVERT cycle j happens at edge RC+1+j; the sampled value is comp_out
    // from lat edges earlier.
    function automatic int first_trip(input int trip, input int lat);
        for (int j = 0; j <= 255; j++) begin
            if (RC + 1 + j - lat >= trip) return j;
        end
        return -1;
    endfunction

    task automatic run_conv(input string name, input int trip, input int rlen,
                            input int exp0, input int exp1);
        int j0, j1, res0, res1, d0, d1, last;
        j0   = first_trip(trip, 0);
        j1   = first_trip(trip, SYNC_LAT);
        res0 = (j0 < 0) ? 255 : j0;
        res1 = (j1 < 0) ? 255 : ((j1 > SYNC_LAT) ? j1 - SYNC_LAT : 0);
        d0   = RC + 1 + ((j0 < 0) ? 255 : j0);
        d1   = RC + 1 + ((j1 < 0) ? 255 : j1);
        last = ((d0 > d1) ? d0 : d1) + 1;
        for (int n = 0; n <= last; n++) begin
            @(negedge clk);
            restart  = (n < rlen);
            comp_out = (n >= trip);
            @(posedge clk);
            #1;
            chk_dut($sformatf("%s a0 n%0d", name, n), en0, rr0, bz0, vl0, ct0,
                    (n >= RC) && (n < d0), n < d0, n >= d0, (n >= d0) ? res0 : old0);
            chk_dut($sformatf("%s a1 n%0d", name, n), en1, rr1, bz1, vl1, ct1,
                    (n >= RC) && (n < d1), n < d1, n >= d1, (n >= d1) ? res1 : old1);
        end
        @(negedge clk);
        restart = 1'b0;
        if (exp0 >= 0) chk({name, " final a0"}, 32'(ct0), 32'(exp0));
        if (exp1 >= 0) chk({name, " final a1"}, 32'(ct1), 32'(exp1));
        old0 = res0;
        old1 = res1;
    endtask

    task automatic chk_reset(input string tag);
        chk_dut({tag, " a0"}, en0, rr0, bz0, vl0, ct0, 1'b0, 1'b0, 1'b0, 0);
        chk_dut({tag, " a1"}, en1, rr1, bz1, vl1, ct1, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        tbl[0] = '{"nominal",     105, 1, 100, 100};
        tbl[1] = '{"immediate",     0, 1,   0,   0};
        tbl[2] = '{"saturate",   1000, 1, 255, 255};
        tbl[3] = '{"trip_cnt1",     4, 1,   0,   0};
        tbl[4] = '{"mid",          50, 1,  45,  45};
        tbl[5] = '{"early",         6, 1,   1,   1};
        tbl[6] = '{"edge255",     260, 1, 255, 255};
        tbl[7] = '{"edge254",     259, 1, 254, 255};
        tbl[8] = '{"held",         20, 6,  15,  15};

        rstn     = 1'b1;
        restart  = 1'b0;
        comp_out = 1'b0;
        #2 rstn  = 1'b0;
        #1 chk_reset("reset async");
        repeat (3) @(posedge clk);
        #1 chk_reset("reset held");
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 chk_reset($sformatf("idle %0d", i));
        end

        for (int i = 0; i < 9; i++) begin
            run_conv(tbl[i].name, tbl[i].trip, tbl[i].rlen, tbl[i].exp0, tbl[i].exp1);
            repeat (2) @(negedge clk);
        end

        for (int i = 0; i < 8; i++) begin
            int t, r;
            t = int'($urandom_range(0, 270));
            r = int'($urandom_range(1, RC + 2));
            run_conv($sformatf("rand%0d t%0d", i, t), t, r, -1, -1);
        end

        // Abort a conversion with an asynchronous reset partway through CONVERT
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            restart  = (n < 1);
            comp_out = 1'b0;
        end
        @(posedge clk);
        #3 rstn = 1'b0;
        #1 chk_reset("abort");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 chk_reset($sformatf("post abort %0d", i));
        end
        old0 = 0;
        old1 = 0;
        run_conv("recover", 30, 1, 25, 25);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
